// File: rtl/dcache_controller_if.sv
// rtl/dcache_controller_if.sv - CPU-side and memory-side signal bundle for dcache_controller
//
// Purpose: groups the CPU MEM-stage access signals and the line-wide backing-memory
// signals. Names keep the _i/_o suffixes as seen from the cache.
// Modports:
//   slave  - the cache controller view (CPU requests and memory responses in)
//   master - the environment view (CPU pipeline plus backing memory)
// Signals:
//   cpu_mem_read_i / cpu_mem_write_i  load / store request
//   cpu_addr_i [31:0]                 byte address
//   cpu_data_i [31:0]                 store data
//   cpu_data_o [31:0]                 load data
//   cpu_stall_o                       pipeline freeze
//   mem_enable_o / mem_write_o        line request, 1 = writeback, 0 = refill
//   mem_addr_o [31:0]                 line-aligned address
//   mem_data_o [255:0]                writeback line
//   mem_data_i [255:0]                refill line
//   mem_ack_i                         single-cycle completion pulse
interface dcache_controller_if;
  logic         cpu_mem_read_i;
  logic         cpu_mem_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_mem_read_i, cpu_mem_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_mem_read_i, cpu_mem_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: answers CPU loads/stores in the access cycle on a hit; on a miss stalls the
// pipeline while a dirty victim is written back and the line is refilled from a slow
// line-wide backing memory, after which the held access completes as a hit.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset (clears valid/dirty, FSM to idle)
//   bus    - dcache_controller_if.slave: CPU request/response and backing-memory handshake
module dcache_controller #(
  parameter int INDEX_BITS = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  dcache_controller_if.slave bus
);
  localparam int LINES     = 2 ** INDEX_BITS;
  localparam int TAG_BITS  = 27 - INDEX_BITS;
  localparam int LINE_BITS = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITEBACK,
    S_WB_GAP,
    S_ALLOCATE,
    S_INSTALL
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [LINE_BITS-1:0] data_mem [LINES];

  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [INDEX_BITS-1:0] miss_idx_q;
  logic                  mem_enable_q;
  logic                  mem_write_q;
  logic [31:0]           mem_addr_q;
  logic [LINE_BITS-1:0]  mem_data_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [2:0]            req_word;
  logic [LINE_BITS-1:0]  cur_line;
  logic                  req;
  logic                  hit;
  logic                  write_hit;
  logic                  refill;
  logic                  miss_start;
  logic                  unused_addr_bits;

  assign req_tag  = bus.cpu_addr_i[31:5+INDEX_BITS];
  assign req_idx  = bus.cpu_addr_i[4+INDEX_BITS:5];
  assign req_word = bus.cpu_addr_i[4:2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign cur_line = data_mem[req_idx];
  assign req      = bus.cpu_mem_read_i | bus.cpu_mem_write_i;
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Stores only land in IDLE; during INSTALL the refilled line already hits but the
  // pipeline is still frozen, so the store is taken the following cycle.
  assign write_hit  = !rst_i && (state_q == S_IDLE) && bus.cpu_mem_write_i && hit;
  assign refill     = !rst_i && (state_q == S_ALLOCATE) && bus.mem_ack_i;
  assign miss_start = !rst_i && (state_q == S_IDLE) && (state_d != S_IDLE);

  always_comb begin
    bus.cpu_stall_o = 1'b0;
    bus.cpu_data_o  = '0;
    if (!rst_i) begin
      bus.cpu_stall_o = (req && !hit) || (state_q != S_IDLE);
      if (bus.cpu_mem_read_i && hit) begin
        bus.cpu_data_o = cur_line[{req_word, 5'b0} +: 32];
      end
    end
  end

  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (bus.mem_ack_i) state_d = S_WB_GAP;
      S_WB_GAP:    state_d = S_ALLOCATE;
      S_ALLOCATE:  if (bus.mem_ack_i) state_d = S_INSTALL;
      S_INSTALL:   state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Enable/write follow the state being entered, so they rise with WRITEBACK/ALLOCATE
  // and drop in the cycle after the ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      mem_enable_q <= (state_d == S_WRITEBACK) || (state_d == S_ALLOCATE);
      mem_write_q  <= (state_d == S_WRITEBACK);
      if (refill) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (write_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Memory address/data only change on state entry, which keeps them stable for the
  // whole request; the refill address comes from the latched miss, not the live CPU bus.
  always_ff @(posedge clk_i) begin
    if (miss_start) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
      if (state_d == S_WRITEBACK) begin
        mem_addr_q <= {tag_mem[req_idx], req_idx, 5'b0};
        mem_data_q <= cur_line;
      end else begin
        mem_addr_q <= {req_tag, req_idx, 5'b0};
      end
    end
    if (!rst_i && (state_q == S_WB_GAP)) begin
      mem_addr_q <= {miss_tag_q, miss_idx_q, 5'b0};
    end
    if (refill) begin
      data_mem[miss_idx_q] <= bus.mem_data_i;
      tag_mem[miss_idx_q]  <= miss_tag_q;
    end
    if (write_hit) begin
      data_mem[req_idx][{req_word, 5'b0} +: 32] <= bus.cpu_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_controller_if bus();
  dcache_controller dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int       delay_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: flat word memory as the CPU should see it, plus what backing memory should hold.
  logic [31:0]  ref_word [int unsigned];
  logic [31:0]  ref_mem  [int unsigned];
  logic [255:0] bmem     [int unsigned];
  bit           res_valid [32];
  bit           res_dirty [32];
  logic [31:0]  res_line  [32];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_val(input logic [31:0] a);
    return ref_word.exists(a) ? ref_word[a] : mem_val(a);
  endfunction

  function automatic logic [255:0] b_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one access at posedge+1, push its expectations, hold it until it completes.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int d_wb, input int d_al);
    logic [31:0]  wa, la;
    logic [255:0] line;
    int           idx, cyc;
    bit           hit;
    cpu_exp_t     ce;
    mem_exp_t     me;
    wa  = {addr[31:2], 2'b00};
    la  = {addr[31:5], 5'b0};
    idx = int'(addr[9:5]);
    hit = res_valid[idx] && (res_line[idx] == la);
    ce.stall = 0;
    if (!hit) begin
      ce.stall = d_al + 3;
      if (res_valid[idx] && res_dirty[idx]) begin
        for (int w = 0; w < 8; w++) begin
          line[w*32 +: 32] = arch_val(res_line[idx] + 32'(w * 4));
          ref_mem[res_line[idx] + 32'(w * 4)] = line[w*32 +: 32];
        end
        me.wr = 1'b1; me.addr = res_line[idx]; me.data = line;
        mem_q.push_back(me);
        delay_q.push_back(d_wb);
        ce.stall += d_wb + 2;
      end
      me.wr = 1'b0; me.addr = la; me.data = '0;
      mem_q.push_back(me);
      delay_q.push_back(d_al);
      res_valid[idx] = 1'b1;
      res_line[idx]  = la;
      res_dirty[idx] = 1'b0;
    end
    ce.rd = rd; ce.wr = wr; ce.addr = addr;
    ce.data = rd ? arch_val(wa) : 32'h0;
    if (wr) begin
      ref_word[wa]   = wdata;
      res_dirty[idx] = 1'b1;
    end
    cpu_q.push_back(ce);
    bus.cpu_mem_read_i  = rd;
    bus.cpu_mem_write_i = wr;
    bus.cpu_addr_i      = addr;
    bus.cpu_data_i      = wdata;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall_o) break;
      cyc++;
      if (cyc > 400) begin
        check(1'b0, "access_timeout", cyc, 400);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.cpu_mem_read_i  = 1'b0;
    bus.cpu_mem_write_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : cpu_monitor
    int stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (bus.cpu_mem_read_i || bus.cpu_mem_write_i) begin
        if (bus.cpu_stall_o) begin
          stall_cnt++;
        end else begin
          if (cpu_q.size() == 0) begin
            check(1'b0, "unexpected_completion", bus.cpu_addr_i, 0);
          end else begin
            e = cpu_q.pop_front();
            check(bus.cpu_data_o === e.data, "cpu_data", bus.cpu_data_o, e.data);
            check(stall_cnt == e.stall, "stall_cycles", stall_cnt, e.stall);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : mem_responder
    bit           busy, unstable, w0;
    int           cnt;
    logic [31:0]  a0;
    logic [255:0] d0;
    mem_exp_t     e;
    busy = 1'b0; unstable = 1'b0; cnt = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack_i = 1'b0;
      if (rst || !bus.mem_enable_o) begin
        busy = 1'b0;
        continue;
      end
      if (!busy) begin
        busy = 1'b1; unstable = 1'b0;
        a0 = bus.mem_addr_o; w0 = bus.mem_write_o; d0 = bus.mem_data_o;
        if (mem_q.size() == 0) begin
          check(1'b0, "unexpected_mem_request", a0, 0);
          cnt = 0;
        end else begin
          e = mem_q.pop_front();
          cnt = delay_q.pop_front();
          check(w0 == e.wr, "mem_write", w0, e.wr);
          check(a0 == e.addr, "mem_addr", a0, e.addr);
          if (e.wr) check(d0 == e.data, "wb_data", d0, e.data);
        end
      end else if (bus.mem_addr_o !== a0 || bus.mem_write_o !== w0 ||
                   (w0 && bus.mem_data_o !== d0)) begin
        unstable = 1'b1;
      end
      if (cnt == 0) begin
        check(!unstable, "mem_stable", unstable, 0);
        if (w0) bmem[a0] = d0;
        else bus.mem_data_i = b_line(a0);
        bus.mem_ack_i = 1'b1;
        busy = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [255:0] l;
    logic [21:0]  tags [3];
    logic [21:0]  tg;
    logic [4:0]   ix;
    logic [2:0]   wd;
    int           r;
    tags[0] = 22'h000000; tags[1] = 22'h000001; tags[2] = 22'h200000;
    for (int i = 0; i < 32; i++) begin
      res_valid[i] = 1'b0; res_dirty[i] = 1'b0; res_line[i] = '0;
    end
    l = b_line(32'h40);
    l[31:0] = 32'h1111_1111;
    bmem[32'h40] = l;
    ref_mem[32'h40] = 32'h1111_1111;

    rst = 1'b1;
    bus.cpu_mem_read_i = 1'b1; bus.cpu_mem_write_i = 1'b0;
    bus.cpu_addr_i = 32'h40;   bus.cpu_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(bus.cpu_stall_o == 1'b0, "reset_stall", bus.cpu_stall_o, 0);
    check(bus.cpu_data_o == 32'h0, "reset_data", bus.cpu_data_o, 0);
    check(bus.mem_enable_o == 1'b0, "reset_enable", bus.mem_enable_o, 0);
    check(bus.mem_write_o == 1'b0, "reset_write", bus.mem_write_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_mem_read_i = 1'b0;
    @(negedge clk);
    check(bus.cpu_stall_o == 1'b0, "idle_stall", bus.cpu_stall_o, 0);
    @(posedge clk); #1;

    access(1, 0, 32'h0000_0040, 0, 0, 5);
    access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 32'h0000_0044, 0, 0, 0);
    access(1, 0, 32'h0000_0440, 0, 2, 3);
    access(1, 0, 32'h0000_0440, 0, 0, 0);
    access(1, 0, 32'h0000_0840, 0, 0, 1);
    access(1, 1, 32'h0000_0848, 32'hCAFE_F00D, 0, 0);
    access(1, 0, 32'h0000_0848, 0, 0, 0);
    idle(2);

    mem_q.push_back('{wr: 1'b0, addr: 32'h1000, data: '0});
    delay_q.push_back(50);
    bus.cpu_mem_read_i = 1'b1; bus.cpu_addr_i = 32'h1004;
    repeat (4) @(negedge clk);
    check(bus.mem_enable_o == 1'b1, "alloc_enable", bus.mem_enable_o, 1);
    check(bus.cpu_stall_o == 1'b1, "alloc_stall", bus.cpu_stall_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_mem_read_i = 1'b0;
    @(negedge clk);
    check(bus.cpu_stall_o == 1'b0, "rst_mid_stall", bus.cpu_stall_o, 0);
    @(negedge clk);
    check(bus.mem_enable_o == 1'b0, "rst_mid_enable", bus.mem_enable_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (res_valid[i] && res_dirty[i]) begin
        for (int w = 0; w < 8; w++) ref_word[res_line[i] + 32'(w * 4)] = mem_val(res_line[i] + 32'(w * 4));
      end
      res_valid[i] = 1'b0; res_dirty[i] = 1'b0;
    end
    access(1, 0, 32'h0000_1004, 0, 0, 2);
    access(1, 0, 32'h0000_0848, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 3));
      ix = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      tg = tags[$urandom_range(0, 2)];
      wd = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      access(r != 1, r == 1 || r == 2, {tg, ix, wd, 2'b00}, $urandom,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
    check(cpu_q.size() == 0, "cpu_queue_drained", cpu_q.size(), 0);
    check(mem_q.size() == 0, "mem_queue_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
